load_store_unit: RTL

//  Memory stage directly downstream of the ALU. Takes the effective address (reg + const) computed by the ALU
//  for lw (4'b0111) and sw (4'b1000) and runs a valid/grant transaction on the data-memory port.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/load_store_unit_if.sv | 38 +++
 rtl/lsu_timeout_ctr.sv | 48 ++++
 rtl/load_store_unit.sv | 138 +++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions. The ALU decode and the load/store unit both use
// this package.
//   OP_LW / OP_SW : memory opcodes that the load/store unit acts on
//   lsu_state_t   : load/store unit FSM states
//   is_mem_op()   : true when an opcode is lw or sw
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam logic [3:0] OP_LW = 4'b0111;
  localparam logic [3:0] OP_SW = 4'b1000;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    RESP
  } lsu_state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// ---------------------------------------------------------------------------
// load_store_unit_if
// Data-memory port that joins the load/store unit and the memory.
//   mem_req    : request valid (driven by the master)
//   mem_we     : 1 = write, 0 = read (driven by the master)
//   mem_addr   : word address (driven by the master)
//   mem_wdata  : write data (driven by the master)
//   mem_gnt    : memory accepted the request this cycle (driven by the slave)
//   mem_rvalid : read data valid this cycle (driven by the slave)
//   mem_rdata  : read data (driven by the slave)
// Modports:
//   master : load/store unit side
//   slave  : memory side
// ---------------------------------------------------------------------------
interface load_store_unit_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/lsu_timeout_ctr.sv
// ---------------------------------------------------------------------------
// lsu_timeout_ctr
// Counts the cycles an access has spent waiting on memory. The counter
// returns to zero while clear_i is high. It advances while enable_i is high.
//   clk       : clock
//   rst_n     : asynchronous, active-low reset
//   clear_i   : return the count to zero (has priority over enable_i)
//   enable_i  : count this cycle
//   expired_o : this is the last cycle allowed (count == TIMEOUT-1 while
//               counting)
// ---------------------------------------------------------------------------
module lsu_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // The FSM leaves REQ/WAIT on the expiry cycle, so the counter never wraps.
  assign expired_o = enable_i && (count_q == LAST);

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// Memory stage that follows the ALU. It turns lw/sw into a valid/grant
// transaction on the data-memory port, stalls the core while the access is
// in progress, returns load data for writeback, and raises a fault pulse
// when an access takes too long.
//   clk        : clock
//   rst_n      : asynchronous, active-low reset
//   issue      : execute-stage instruction valid
//   opcode     : instruction opcode (only lw/sw are acted on)
//   alu_addr   : effective word address from the ALU
//   store_data : value to store for sw
//   stall      : hold the PC and the pipeline
//   wb_valid   : one-cycle pulse; write wb_data to the lw destination
//   wb_data    : load result, 0 when there is no successful load
//   fault      : one-cycle pulse when the access timed out
//   mem        : data-memory port (master side)
// ---------------------------------------------------------------------------
module load_store_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue,
  input  logic [3:0]        opcode,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] store_data,
  output logic              stall,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic              fault,
  load_store_unit_if.master mem
);

  lsu_state_t        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              mem_req_q;
  logic              wb_valid_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              fault_q;
  logic              expired;
  logic              start;

  assign start = (state_q == IDLE) && issue && is_mem_op(opcode);

  lsu_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (state_q == IDLE),
    .enable_i  ((state_q == REQ) || (state_q == WAIT)),
    .expired_o (expired)
  );

  // Completion and timeout are checked in priority order, so an access that
  // completes on the expiry cycle finishes normally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      mem_req_q  <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      fault_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            addr_q    <= alu_addr;
            wdata_q   <= store_data;
            we_q      <= (opcode == OP_SW);
            mem_req_q <= 1'b1;
            state_q   <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_gnt) begin
            mem_req_q <= 1'b0;
            if (we_q) begin
              state_q <= RESP;
            end else if (mem.mem_rvalid) begin
              wb_valid_q <= 1'b1;
              wb_data_q  <= mem.mem_rdata;
              state_q    <= RESP;
            end else if (expired) begin
              fault_q <= 1'b1;
              state_q <= RESP;
            end else begin
              state_q <= WAIT;
            end
          end else if (expired) begin
            mem_req_q <= 1'b0;
            fault_q   <= 1'b1;
            state_q   <= RESP;
          end
        end
        WAIT: begin
          if (mem.mem_rvalid) begin
            wb_valid_q <= 1'b1;
            wb_data_q  <= mem.mem_rdata;
            state_q    <= RESP;
          end else if (expired) begin
            fault_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          wb_valid_q <= 1'b0;
          wb_data_q  <= '0;
          fault_q    <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // stall is combinational so that it is already high in the issue cycle.
  assign stall = start || (state_q == REQ) || (state_q == WAIT);

  assign wb_valid      = wb_valid_q;
  assign wb_data       = wb_data_q;
  assign fault         = fault_q;
  assign mem.mem_req   = mem_req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule
